// File: rtl/pcileech_rst_ctl.sv
// Reset controller: button/PERST# synchronizers, debouncer, POR/RUN/PRESS/HELD FSM, uptime counter and power-on blink.
// Optional macro PCILEECH_RST_PERST_EN: a synchronized PERST# assertion forces the FSM back into POR.
module pcileech_rst_ctl #(
    parameter int POR_CYCLES        = 64,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 500000000,
    parameter int BLINK_BIT         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       user_sw_n,
    input  logic       pcie_perst_n,
    output logic       rst_sys,
    output logic       ft601_rst_n,
    output logic       rst_cfg_reload,
    output logic       led_pwronblink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PRESS = 2'd2,
        ST_HELD  = 2'd3
    } state_t;

    localparam logic [31:0] POR_LAST   = 32'(POR_CYCLES - 1);
    localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] PRESS_LAST = 32'(LONG_PRESS_CYCLES - 1);

    logic [1:0]  r_sw_sync;
    logic        r_db_pressed;
    logic [31:0] r_db_cnt;
    state_t      r_state;
    logic [31:0] r_por_cnt;
    logic [31:0] r_press_cnt;
    logic        r_reload;
    logic        r_rst_sys;
    logic [63:0] r_uptime;
    logic        r_led;

    state_t      w_state_next;
    logic [31:0] w_por_cnt_next;
    logic [31:0] w_press_cnt_next;
    logic        w_reload_next;
    logic        w_sw_pressed;
    logic        w_perst_active;
    logic        w_blink;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_sw_sync <= 2'b11;
        else     r_sw_sync <= {r_sw_sync[0], user_sw_n};
    end

    assign w_sw_pressed = ~r_sw_sync[1];

`ifdef PCILEECH_RST_PERST_EN
    logic [1:0] r_perst_sync;

    always_ff @(posedge clk) begin
        if (rst) r_perst_sync <= 2'b11;
        else     r_perst_sync <= {r_perst_sync[0], pcie_perst_n};
    end

    assign w_perst_active = ~r_perst_sync[1];
`else
    logic w_unused_perst;

    assign w_unused_perst = pcie_perst_n;
    assign w_perst_active = 1'b0;
`endif

    // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_pressed <= 1'b0;
            r_db_cnt     <= '0;
        end else if (w_sw_pressed == r_db_pressed) begin
            r_db_cnt     <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_pressed <= w_sw_pressed;
            r_db_cnt     <= '0;
        end else begin
            r_db_cnt     <= r_db_cnt + 32'd1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_por_cnt_next   = r_por_cnt;
        w_press_cnt_next = r_press_cnt;
        w_reload_next    = 1'b0;
        case (r_state)
            ST_POR: begin
                if (r_db_pressed) begin
                    w_por_cnt_next = '0;
                end else if (r_por_cnt == POR_LAST) begin
                    w_state_next   = ST_RUN;
                    w_por_cnt_next = '0;
                end else begin
                    w_por_cnt_next = r_por_cnt + 32'd1;
                end
            end
            ST_RUN: begin
                if (r_db_pressed) begin
                    w_state_next     = ST_PRESS;
                    w_press_cnt_next = '0;
                end
            end
            ST_PRESS: begin
                // Release is checked first so it beats a same-cycle terminal count.
                if (!r_db_pressed) begin
                    w_state_next   = ST_POR;
                    w_por_cnt_next = '0;
                end else if (r_press_cnt == PRESS_LAST) begin
                    w_state_next  = ST_HELD;
                    w_reload_next = 1'b1;
                end else begin
                    w_press_cnt_next = r_press_cnt + 32'd1;
                end
            end
            ST_HELD: begin
                if (!r_db_pressed) begin
                    w_state_next   = ST_POR;
                    w_por_cnt_next = '0;
                end
            end
            default: w_state_next = ST_POR;
        endcase
        if (w_perst_active) begin
            w_state_next   = ST_POR;
            w_por_cnt_next = '0;
            w_reload_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_POR;
            r_por_cnt   <= '0;
            r_press_cnt <= '0;
            r_reload    <= 1'b0;
            r_rst_sys   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_por_cnt   <= w_por_cnt_next;
            r_press_cnt <= w_press_cnt_next;
            r_reload    <= w_reload_next;
            r_rst_sys   <= (w_state_next != ST_RUN);
        end
    end

    // Blink only during the first 2^(BLINK_BIT+3) cycles of uptime.
    assign w_blink = r_uptime[BLINK_BIT] & (r_uptime[63:BLINK_BIT+3] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_uptime <= '0;
            r_led    <= 1'b0;
        end else begin
            if (r_rst_sys)             r_uptime <= '0;
            else if (r_uptime != '1)   r_uptime <= r_uptime + 64'd1;
            r_led <= r_db_pressed ^ w_blink;
        end
    end

    assign rst_sys        = r_rst_sys;
    assign ft601_rst_n    = ~r_rst_sys;
    assign rst_cfg_reload = r_reload;
    assign led_pwronblink = r_led;
    assign state          = r_state;

endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// Self-checking bench for pcileech_rst_ctl (POR=8, DEBOUNCE=4, LONG=100, BLINK_BIT=2).
// Reload pulses are scoreboarded: the expected cycle is queued when the press is driven.
module tb_pcileech_rst_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       user_sw_n;
    logic       pcie_perst_n;
    logic       rst_sys;
    logic       ft601_rst_n;
    logic       rst_cfg_reload;
    logic       led_pwronblink;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_reload_q[$];

    pcileech_rst_ctl #(
        .POR_CYCLES       (8),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(100),
        .BLINK_BIT        (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .user_sw_n      (user_sw_n),
        .pcie_perst_n   (pcie_perst_n),
        .rst_sys        (rst_sys),
        .ft601_rst_n    (ft601_rst_n),
        .rst_cfg_reload (rst_cfg_reload),
        .led_pwronblink (led_pwronblink),
        .state          (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed reload pulse must match the head of the queue.
    always @(negedge clk) begin : reload_monitor
        int e;
        if (rst_cfg_reload === 1'b1) begin
            checks++;
            if (exp_reload_q.size() == 0) begin
                errors++;
                $display("FAIL reload_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_reload_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL reload_cycle: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_state(input logic [1:0] exp_st, input logic exp_rs, input string name);
        checks++;
        if (state !== exp_st || rst_sys !== exp_rs || ft601_rst_n !== ~exp_rs) begin
            errors++;
            $display("FAIL %s: state=%0d rst_sys=%b ft601_rst_n=%b, required state=%0d rst_sys=%b",
                     name, state, rst_sys, ft601_rst_n, exp_st, exp_rs);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && state !== target; i++) tick(1);
        checks++;
        if (state !== target) begin
            errors++;
            $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, state, max_cycles, target);
        end
    endtask

    task automatic expect_no_pending(input string name);
        checks++;
        if (exp_reload_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d reload pulses missing, required 0", name, exp_reload_q.size());
            exp_reload_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; user_sw_n = 1'b1; pcie_perst_n = 1'b1;
        tick(3);
        expect_state(2'd0, 1'b1, "reset_state");
        checks++;
        if (rst_cfg_reload !== 1'b0 || led_pwronblink !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: reload=%b led=%b, required 0 0", rst_cfg_reload, led_pwronblink);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_state(2'd0, 1'b1, "por_hold");
            tick(1);
        end
        expect_state(2'd1, 1'b0, "por_done");
    endtask

    // Runs directly after test_reset: uptime is 0 on the first sample.
    task automatic test_blink();
        int  up;
        logic exp_led;
        up = 0;
        for (int i = 0; i < 48; i++) begin
            exp_led = (up > 0) && ((up - 1) < 32) && (((up - 1) & 4) != 0);
            checks++;
            if (led_pwronblink !== exp_led) begin
                errors++;
                $display("FAIL blink_u%0d: led=%b, required %b", up, led_pwronblink, exp_led);
            end
            tick(1);
            up++;
        end
    endtask

    task automatic test_short_press();
        user_sw_n = 1'b0;
        tick(3);
        user_sw_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            expect_state(2'd1, 1'b0, "short_press");
            tick(1);
        end
    endtask

    task automatic test_medium_press();
        user_sw_n = 1'b0;
        tick(6);
        expect_state(2'd1, 1'b0, "medium_before_press");
        tick(1);
        expect_state(2'd2, 1'b1, "medium_press_entry");
        tick(43);
        user_sw_n = 1'b1;
        tick(6);
        expect_state(2'd2, 1'b1, "medium_before_release");
        tick(1);
        for (int i = 0; i < 8; i++) begin
            expect_state(2'd0, 1'b1, "medium_por");
            tick(1);
        end
        expect_state(2'd1, 1'b0, "medium_run");
        expect_no_pending("medium_reload");
    endtask

    task automatic test_long_press();
        exp_reload_q.push_back(cyc + 107);
        user_sw_n = 1'b0;
        tick(106);
        expect_state(2'd2, 1'b1, "long_before_reload");
        tick(1);
        expect_state(2'd3, 1'b1, "long_held");
        tick(43);
        expect_state(2'd3, 1'b1, "long_held_late");
        checks++;
        if (led_pwronblink !== 1'b1) begin
            errors++;
            $display("FAIL long_led_inverted: led=%b, required 1", led_pwronblink);
        end
        tick(50);
        user_sw_n = 1'b1;
        wait_state(2'd0, 10, "long_release_por");
        wait_state(2'd1, 12, "long_release_run");
        expect_no_pending("long_reload");
    endtask

    task automatic test_release_at_terminal();
        user_sw_n = 1'b0;
        tick(100);
        user_sw_n = 1'b1;
        tick(6);
        expect_state(2'd2, 1'b1, "terminal_press");
        tick(1);
        expect_state(2'd0, 1'b1, "terminal_release_wins");
        wait_state(2'd1, 12, "terminal_run");
        expect_no_pending("terminal_reload");
    endtask

    task automatic test_rst_abort();
        user_sw_n = 1'b0;
        tick(100);
        rst = 1'b1;
        tick(2);
        expect_state(2'd0, 1'b1, "abort_in_rst");
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            expect_state(2'd0, 1'b1, "abort_por_pressed");
            tick(1);
        end
        user_sw_n = 1'b1;
        wait_state(2'd1, 40, "abort_run");
        expect_no_pending("abort_reload");
    endtask

`ifdef PCILEECH_RST_PERST_EN
    task automatic test_perst();
        user_sw_n = 1'b0;
        tick(104);
        pcie_perst_n = 1'b0;
        user_sw_n    = 1'b1;
        tick(2);
        expect_state(2'd2, 1'b1, "perst_press_cnt99");
        tick(1);
        expect_state(2'd0, 1'b1, "perst_force_por");
        tick(13);
        pcie_perst_n = 1'b1;
        tick(9);
        expect_state(2'd0, 1'b1, "perst_por_tail");
        tick(1);
        expect_state(2'd1, 1'b0, "perst_run");
        expect_no_pending("perst_reload");
    endtask
`else
    task automatic test_perst();
        pcie_perst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            expect_state(2'd1, 1'b0, "perst_ignored");
        end
        pcie_perst_n = 1'b1;
        tick(4);
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_short_press();
        test_medium_press();
        test_long_press();
        test_release_at_terminal();
        test_rst_abort();
        test_perst();
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
